// File: rtl/exec_div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencing slice.
// Holds the ALU op-class and op-control encodings, the divider iteration
// count, the divide-controller state enum and small op-decoding helpers.
package exec_div_ctrl_pkg;

  localparam int SHIFT_COUNT = 32;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'd0,
    ALUOP_ALU = 2'd1,
    ALUOP_MUL = 2'd2,
    ALUOP_DIV = 2'd3
  } aluop_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_DIV  = 4'h8,
    ALU_DIVU = 4'h9,
    ALU_REM  = 4'ha,
    ALU_REMU = 4'hb
  } alucontrol_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divctrl_state_t;

  function automatic logic is_signed_div(alucontrol_t op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(alucontrol_t op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/exec_div_ctrl_if.sv
// Bus between the divide controller and the iterative divider.
// master (controller): drives div_fire, div_flush, div_alucontrol, div_a,
//                      div_b; receives div_valid, divresult.
// slave  (divider):    the mirror image.
interface exec_div_ctrl_if;
  import exec_div_ctrl_pkg::*;

  logic        div_fire;
  logic        div_flush;
  alucontrol_t div_alucontrol;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_valid;
  logic [31:0] divresult;

  modport master (
    output div_fire,
    output div_flush,
    output div_alucontrol,
    output div_a,
    output div_b,
    input  div_valid,
    input  divresult
  );

  modport slave (
    input  div_fire,
    input  div_flush,
    input  div_alucontrol,
    input  div_a,
    input  div_b,
    output div_valid,
    output divresult
  );

endinterface

// File: rtl/exec_div_special.sv
// Combinational resolver for the RISC-V divide corner cases that never
// reach the divider.
// Ports:
//   alucontrol     in   DIV/DIVU/REM/REMU
//   in_a, in_b     in   dividend, divisor
//   is_special     out  operands hit a corner case
//   special_result out  architectural result for that corner case
module exec_div_special
  import exec_div_ctrl_pkg::*;
(
  input  alucontrol_t alucontrol,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        is_special,
  output logic [31:0] special_result
);

  always_comb begin
    is_special     = 1'b0;
    special_result = '0;
    // Divide-by-zero outranks signed overflow (0x80000000 / 0 is a div-by-zero).
    if (in_b == 32'h0) begin
      is_special     = 1'b1;
      special_result = is_rem_op(alucontrol) ? in_a : 32'hffff_ffff;
    end else if (is_signed_div(alucontrol) && in_a == 32'h8000_0000 &&
                 in_b == 32'hffff_ffff) begin
      is_special     = 1'b1;
      special_result = is_rem_op(alucontrol) ? 32'h0 : 32'h8000_0000;
    end
  end

endmodule

// File: rtl/exec_div_ctrl.sv
// Sequencing controller for the EX-stage iterative divider.
// Resolves corner cases combinationally, reuses the divider's held result
// when the same operands/signedness come round again, otherwise launches
// the divider and stalls EX until the result is back.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            EX flush
//   ex_valid         EX holds a valid instruction
//   ex_advance       EX instruction leaves EX this cycle
//   aluop/alucontrol EX op class and op
//   in_a, in_b       dividend, divisor
//   div_stall        hold EX and earlier stages
//   div_result       result for the EX mux
//   div_bus          divider bus (master side)
//
// state | meaning
// IDLE  | no divide in flight; specials and cache hits answered here
// BUSY  | divider running, EX stalled
// DONE  | result held in res_q until EX advances
module exec_div_ctrl
  import exec_div_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic            ex_advance,
  input  aluop_t          aluop,
  input  alucontrol_t     alucontrol,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  output logic            div_stall,
  output logic [31:0]     div_result,
  exec_div_ctrl_if.master div_bus
);

  divctrl_state_t state_q, state_d;

  logic        c_valid;
  logic [31:0] c_a;
  logic [31:0] c_b;
  logic        c_signed;
  logic [31:0] res_q;
  alucontrol_t op_q;

  logic        div_op;
  logic        signed_op;
  logic        hit;
  logic        launch;
  logic        is_special;
  logic [31:0] special_result;

  exec_div_special u_special (
    .alucontrol     (alucontrol),
    .in_a           (in_a),
    .in_b           (in_b),
    .is_special     (is_special),
    .special_result (special_result)
  );

  assign div_op    = ex_valid && (aluop == ALUOP_DIV);
  assign signed_op = is_signed_div(alucontrol);
  assign hit       = c_valid && (c_a == in_a) && (c_b == in_b) && (c_signed == signed_op);

  assign div_bus.div_a = in_a;
  assign div_bus.div_b = in_b;

  // Kept apart from the main decode: divresult is a function of this, and
  // div_result is a function of divresult.
  always_comb begin
    div_bus.div_alucontrol = op_q;
    if (state_q == IDLE && div_op) begin
      div_bus.div_alucontrol = alucontrol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    div_stall  = 1'b0;
    div_result = '0;
    div_bus.div_flush = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_op) begin
          if (is_special) begin
            div_result = special_result;
          end else if (hit) begin
            div_result = div_bus.divresult;
          end else begin
            launch    = 1'b1;
            div_stall = 1'b1;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        div_stall = div_op;
        if (div_bus.div_valid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (div_op) begin
          div_result = res_q;
        end
        if (ex_advance) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flushed instruction must neither hold the pipe nor start the divider.
    if (flush) begin
      state_d           = IDLE;
      launch            = 1'b0;
      div_stall         = 1'b0;
      div_bus.div_flush = 1'b1;
    end

    if (rst) begin
      launch            = 1'b0;
      div_stall         = 1'b0;
      div_bus.div_flush = 1'b0;
    end

    div_bus.div_fire = launch;
  end

  // Operand tags are captured at launch with the entry marked invalid, since
  // the divider's held state is being overwritten; the entry becomes valid
  // once the divider reports completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid  <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_signed <= 1'b0;
      res_q    <= '0;
      op_q     <= ALU_DIVU;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (launch) begin
      c_valid  <= 1'b0;
      c_a      <= in_a;
      c_b      <= in_b;
      c_signed <= signed_op;
      op_q     <= alucontrol;
    end else if (state_q == BUSY && div_bus.div_valid) begin
      c_valid <= 1'b1;
      res_q   <= div_bus.divresult;
    end
  end

endmodule

// File: tb/tb_exec_div_ctrl.sv
module tb_exec_div_ctrl;
  import exec_div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_advance = 1'b0;
  aluop_t      aluop = ALUOP_ADD;
  alucontrol_t alucontrol = ALU_ADD;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        div_stall;
  logic [31:0] div_result;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  // expected-cache tracker
  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_signed = 1'b0;

  exec_div_ctrl_if dbus();

  always #5 clk = ~clk;

  exec_div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_advance (ex_advance),
    .aluop      (aluop),
    .alucontrol (alucontrol),
    .in_a       (in_a),
    .in_b       (in_b),
    .div_stall  (div_stall),
    .div_result (div_result),
    .div_bus    (dbus)
  );

  function automatic logic [31:0] ref_div(alucontrol_t op, logic [31:0] a, logic [31:0] b);
    logic sgn;
    sgn = (op == ALU_DIV) || (op == ALU_REM);
    if (b == 32'h0) return (op == ALU_REM || op == ALU_REMU) ? a : 32'hffff_ffff;
    if (sgn && a == 32'h8000_0000 && b == 32'hffff_ffff)
      return (op == ALU_DIV) ? 32'h8000_0000 : 32'h0;
    case (op)
      ALU_DIV:  return $signed(a) / $signed(b);
      ALU_REM:  return $signed(a) % $signed(b);
      ALU_DIVU: return a / b;
      default:  return a % b;
    endcase
  endfunction

  // Divider model: busy for SHIFT_COUNT cycles after the launch cycle,
  // div_valid pulse in the next one, result held from the launched operands.
  logic [5:0]  cnt = '0;
  logic [31:0] h_a = '0;
  logic [31:0] h_b = '0;

  always @(posedge clk) begin
    if (rst || dbus.div_flush) begin
      cnt <= '0;
    end else if (dbus.div_fire) begin
      cnt <= 6'(SHIFT_COUNT + 1);
      h_a <= dbus.div_a;
      h_b <= dbus.div_b;
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end
  end

  assign dbus.div_valid = (cnt == 6'd1);
  assign dbus.divresult = ref_div(dbus.div_alucontrol, h_a, h_b);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input alucontrol_t op, input logic [31:0] a, input logic [31:0] b);
    ex_valid   = 1'b1;
    aluop      = ALUOP_DIV;
    alucontrol = op;
    in_a       = a;
    in_b       = b;
    ex_advance = 1'b0;
  endtask

  task automatic run_op(input string tag, input alucontrol_t op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int   exp_stall;
    int   stalls;
    int   fires;
    bit   got_it;
    logic sp;
    logic sgn;
    logic hit;
    logic [31:0] exp;
    sgn = (op == ALU_DIV) || (op == ALU_REM);
    sp  = (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hffff_ffff);
    hit = m_valid && m_a == a && m_b == b && m_signed == sgn;
    exp_stall = (sp || hit) ? 0 : SHIFT_COUNT + 2;
    exp_q.push_back(ref_div(op, a, b));

    @(posedge clk); #1;
    drive_op(op, a, b);
    stalls = 0;
    fires  = 0;
    got_it = 1'b0;
    for (int n = 0; n < 200 && !got_it; n++) begin
      @(negedge clk);
      if (dbus.div_fire) fires++;
      if (!div_stall) got_it = 1'b1;
      else stalls++;
    end
    if (!got_it) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    exp = exp_q.pop_front();
    check_val({tag, "_result"}, div_result, exp);
    check_val({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
    check_val({tag, "_fires"}, 32'(fires), (exp_stall != 0) ? 32'd1 : 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val({tag, "_hold_result"}, div_result, exp);
      check_val({tag, "_hold_stall"}, {31'd0, div_stall}, 32'd0);
      check_val({tag, "_hold_fire"}, {31'd0, dbus.div_fire}, 32'd0);
    end
    ex_advance = 1'b1;
    @(posedge clk); #1;
    ex_advance = 1'b0;
    ex_valid   = 1'b0;
    aluop      = ALUOP_ADD;
    if (exp_stall != 0) begin
      m_valid  = 1'b1;
      m_a      = a;
      m_b      = b;
      m_signed = sgn;
    end
  endtask

  initial begin
    // outputs forced low during reset even with a miss and a flush pending
    drive_op(ALU_DIVU, 32'd100, 32'd7);
    flush = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_stall", {31'd0, div_stall}, 32'd0);
    check_val("rst_fire", {31'd0, dbus.div_fire}, 32'd0);
    check_val("rst_flush", {31'd0, dbus.div_flush}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    flush = 1'b0;
    ex_valid = 1'b0;

    // non-divide op with a zero divisor must not answer
    ex_valid = 1'b1; aluop = ALUOP_ALU; alucontrol = ALU_DIV; in_a = 32'd9; in_b = 32'd0;
    @(negedge clk);
    check_val("nondiv_stall", {31'd0, div_stall}, 32'd0);
    check_val("nondiv_result", div_result, 32'd0);
    check_val("nondiv_fire", {31'd0, dbus.div_fire}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;

    run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 0);
    run_op("remu_100_7_hit", ALU_REMU, 32'd100, 32'd7, 0);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hffff_ffff, 0);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hffff_ffff, 0);
    run_op("divu_by0", ALU_DIVU, 32'd12345, 32'd0, 0);
    run_op("remu_5_0", ALU_REMU, 32'd5, 32'd0, 0);
    run_op("div_by0", ALU_DIV, 32'h8000_0000, 32'd0, 0);
    run_op("div_m7_2", ALU_DIV, 32'hffff_fff9, 32'd2, 0);
    run_op("remu_m7_2", ALU_REMU, 32'hffff_fff9, 32'd2, 0);
    run_op("rem_m7_2", ALU_REM, 32'hffff_fff9, 32'd2, 0);
    run_op("div_m7_2_hit", ALU_DIV, 32'hffff_fff9, 32'd2, 0);

    // flush at BUSY cycle 10
    @(posedge clk); #1;
    drive_op(ALU_DIV, 32'h1234_5678, 32'hffff_ff00);
    @(negedge clk);
    check_val("fl_fire", {31'd0, dbus.div_fire}, 32'd1);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_val("fl_flush", {31'd0, dbus.div_flush}, 32'd1);
    check_val("fl_fire_sup", {31'd0, dbus.div_fire}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    ex_valid = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    check_val("fl_after_flush", {31'd0, dbus.div_flush}, 32'd0);
    check_val("fl_after_stall", {31'd0, div_stall}, 32'd0);
    run_op("fl_reissue", ALU_DIV, 32'h1234_5678, 32'hffff_ff00, 0);

    // DONE held for 5 cycles
    run_op("hold_divu", ALU_DIVU, 32'hdead_beef, 32'h0000_1234, 5);

    // reset mid-BUSY
    @(posedge clk); #1;
    drive_op(ALU_DIVU, 32'd1000, 32'd3);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_stall", {31'd0, div_stall}, 32'd0);
    check_val("mid_rst_fire", {31'd0, dbus.div_fire}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ex_valid = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    check_val("post_rst_stall", {31'd0, div_stall}, 32'd0);
    check_val("post_rst_result", div_result, 32'd0);
    run_op("post_rst_divu", ALU_DIVU, 32'd1000, 32'd3, 0);

    // idle reset drops a valid cache entry
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_valid = 1'b0;
    run_op("rst_inval_remu", ALU_REMU, 32'd1000, 32'd3, 0);

    // random mix from a small operand pool so hits recur
    begin
      logic [31:0] pa[4];
      logic [31:0] pb[4];
      alucontrol_t pop[4];
      pa[0] = 32'd100; pa[1] = 32'hffff_fff9; pa[2] = 32'h8000_0000; pa[3] = 32'd12345;
      pb[0] = 32'd7;   pb[1] = 32'd2;         pb[2] = 32'd0;         pb[3] = 32'hffff_ffff;
      pop[0] = ALU_DIV; pop[1] = ALU_DIVU; pop[2] = ALU_REM; pop[3] = ALU_REMU;
      for (int i = 0; i < 14; i++) begin
        run_op($sformatf("rnd%0d", i), pop[$urandom_range(3)], pa[$urandom_range(1)],
               pb[$urandom_range(3)], 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_div_ctrl.md
# exec_div_ctrl

Sequencing controller for the EX-stage iterative divider (exec_divisor) of the RV32IM core. It decodes DIV/DIVU/REM/REMU in EX and resolves RISC-V special cases (divide-by-zero, signed overflow) without launching the divider. It reuses the divider's held state when the same operands are seen again (e.g. DIV followed by REM), launches the divider otherwise, and stalls EX until the result is ready. It sits between the EX pipeline register and the divider; its result feeds the EX result mux.

## Interface
- No parameters; iteration count `SHIFT_COUNT` (= 32) comes from `riscv_defines`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush of EX.
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_advance`  in  1  EX instruction leaves EX this cycle.
- `aluop`  in  aluop_t  EX op class; `ALUOP_DIV` selects this block.
- `alucontrol`  in  alucontrol_t  `ALU_DIV` / `ALU_DIVU` / `ALU_REM` / `ALU_REMU`.
- `in_a`, `in_b`  in  32  dividend and divisor.
- `div_stall`  out  1  hold EX and earlier stages.
- `div_result`  out  32  result for the EX mux; valid when `div_op && !div_stall`.
- `div_fire`  out  1  one-cycle launch pulse to the divider (its `ex_fire`, with its `aluop` tied to `ALUOP_DIV`).
- `div_flush`  out  1  divider flush.
- `div_alucontrol`  out  alucontrol_t  op driven to the divider.
- `div_a`, `div_b`  out  32  operands to the divider (pass-through of `in_a`/`in_b`).
- `div_valid`  in  1  divider done pulse.
- `divresult`  in  32  divider result for `div_alucontrol`.

## Operation
- `div_op = ex_valid && aluop == ALUOP_DIV`. `signed_op = alucontrol ∈ {ALU_DIV, ALU_REM}`.
- Special cases, priority in this order, resolved combinationally in IDLE:
  - `in_b == 0`: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `in_a`.
  - Signed op with `in_a == 0x80000000` and `in_b == 0xFFFFFFFF`: DIV → 0x80000000; REM → 0.
- Cache: registers `{c_valid, c_a, c_b, c_signed}`.
  - Hit when `c_valid && c_a == in_a && c_b == in_b && c_signed == signed_op`.
  - On a hit, `div_alucontrol = alucontrol` and `div_result = divresult`. The divider holds its quotient/remainder while idle, so a hit needs no launch.
- FSM `divctrl_state_t`: IDLE, BUSY, DONE.
  - IDLE, `div_op`, special or hit: no stall, no state change.
  - IDLE, `div_op`, miss: `div_fire = 1`; latch `alucontrol` into `op_q`; `div_stall = 1`; go to BUSY.
  - BUSY: `div_stall = 1`; `div_alucontrol = op_q`. On `div_valid`: `res_q <= divresult`; `c_valid <= 1`; `c_a`/`c_b`/`c_signed` <= the launched operands and signedness; go to DONE.
  - DONE: `div_stall = 0`; `div_result = res_q`; `div_alucontrol = op_q`. When `ex_advance`, go to IDLE.
- Non-divide ops: `div_stall = 0`, `div_result = 0`, no state change.
- Flush in any state: next state IDLE; `div_flush = 1` that cycle; `c_valid <= 0`; `div_fire` is suppressed in that same cycle.
- `div_valid` received outside BUSY is ignored.

## Timing
- Reset values: state IDLE; `c_valid`, `res_q` = 0; `op_q` = `ALU_DIVU`.
- While `rst` is high, `div_stall`, `div_fire` and `div_flush` are forced to 0.
- Special-case or cache hit: 0 stall cycles; result is valid in the same cycle.
- Miss, with launch in cycle 0:
  - Divider is busy in cycles 1..32 and pulses `div_valid` in cycle 33.
  - `div_stall` is high in cycles 0..33; DONE with the result is presented in cycle 34.
  - Total: 34 stall cycles.
- `div_fire` is high for exactly one cycle per launch. It is never asserted in BUSY or DONE.
- Reset mid-operation: next cycle is IDLE with the cache invalid. The divider's own reset is separate.

## Structure
- `riscv_defines` holds `aluop_t`, `alucontrol_t`, `SHIFT_COUNT`, and the new `divctrl_state_t` enum (IDLE/BUSY/DONE).
- One sub-module is natural: `exec_div_special`. It is purely combinational, takes `alucontrol`, `in_a` and `in_b`, and outputs `is_special` and `special_result`.

## Test plan
- DIVU 100/7 (miss) → `div_fire` pulse in cycle 0; `div_stall` for 34 cycles; `div_result = 14` in cycle 34.
- REMU 100/7 right after the above → hit; no stall; `div_result = 2` in the same cycle; no `div_fire`.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM of the same operands → 0, both with no stall. DIVU x/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- DIV −7/2 (miss) → 0xFFFFFFFD. A following REMU −7/2 → miss (signedness differs), relaunched.
- Flush at cycle 10 of BUSY → `div_flush` pulse, IDLE next cycle, stall drops. Re-issuing the same DIV then misses and takes the full 34 stall cycles.
- DONE held with `ex_advance = 0` for 5 cycles → `div_result` stable, `div_stall = 0`. Assert `rst` mid-BUSY → IDLE, outputs 0, next op misses.
